// File: rtl/hm01b0_capture.sv
// HM01B0 parallel camera receiver: samples pixdata/hsync/vsync on posedge mclk and emits a
// registered, coordinate-tagged pixel stream with frame strobes and geometry error pulses.
module hm01b0_capture #(
  parameter int unsigned WIDTH  = 320,
  parameter int unsigned HEIGHT = 240,
  parameter int unsigned XW     = 9,
  parameter int unsigned YW     = 8
) (
  input  logic          mclk,
  input  logic          nreset,
  input  logic          enable,
  input  logic [7:0]    pixdata,
  input  logic          hsync,
  input  logic          vsync,
  output logic          pix_valid,
  output logic [7:0]    pix_data,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic          frame_start,
  output logic          frame_end,
  output logic          line_error,
  output logic          frame_error,
  output logic [15:0]   frame_count,
  output logic          busy
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    ARMED = 2'd1,
    FRAME = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          hsync_q, vsync_q;
  logic [XW-1:0] col_cnt, col_nxt;
  logic [YW-1:0] line_cnt, line_nxt;
  logic          line_over, over_nxt;
  logic          first_pix, first_nxt;
  logic          dropped, dropped_nxt;

  logic          pix_valid_nxt;
  logic [DW-1:0] pix_data_nxt;
  logic [XW-1:0] pix_x_nxt;
  logic [YW-1:0] pix_y_nxt;
  logic          frame_start_nxt, frame_end_nxt;
  logic          line_error_nxt, frame_error_nxt;
  logic [CW-1:0] frame_count_nxt;
  logic          busy_nxt;

  logic          vs_rise, vs_fall, line_close, line_in_range, col_in_range;

  assign vs_rise       = vsync & ~vsync_q;
  assign vs_fall       = ~vsync & vsync_q;
  // A line ends on an hsync fall, or when vsync drops under a still-active line.
  assign line_close    = hsync_q & (~hsync | vs_fall);
  assign line_in_range = line_cnt < YW'(HEIGHT);
  assign col_in_range  = col_cnt < XW'(WIDTH);

  always_ff @(posedge mclk or negedge nreset) begin
    if (!nreset) state <= SYNC;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      SYNC:    if (!vsync)            state_nxt = ARMED;
      ARMED:   if (vs_rise && enable) state_nxt = FRAME;
      FRAME:   if (vs_fall)           state_nxt = ARMED;
      default:                        state_nxt = SYNC;
    endcase
  end

  always_comb begin
    pix_valid_nxt   = 1'b0;
    pix_data_nxt    = pix_data;
    pix_x_nxt       = pix_x;
    pix_y_nxt       = pix_y;
    frame_start_nxt = 1'b0;
    frame_end_nxt   = 1'b0;
    line_error_nxt  = 1'b0;
    frame_error_nxt = 1'b0;
    frame_count_nxt = frame_count;
    col_nxt         = col_cnt;
    line_nxt        = line_cnt;
    over_nxt        = line_over;
    first_nxt       = first_pix;
    dropped_nxt     = dropped;
    busy_nxt        = (state_nxt == FRAME);

    unique case (state)
      ARMED: begin
        if (vs_rise && enable) begin
          col_nxt     = '0;
          line_nxt    = '0;
          over_nxt    = 1'b0;
          dropped_nxt = 1'b0;
          first_nxt   = 1'b1;
        end
      end
      FRAME: begin
        if (hsync && !vs_fall) begin
          if (col_in_range) begin
            if (line_in_range) begin
              pix_valid_nxt   = 1'b1;
              pix_data_nxt    = pixdata;
              pix_x_nxt       = col_cnt;
              pix_y_nxt       = line_cnt;
              frame_start_nxt = first_pix;
              first_nxt       = 1'b0;
            end
            col_nxt = col_cnt + XW'(1);
          end else if (!dropped) begin
            // Long line: flag once, on the first pixel that no longer fits.
            dropped_nxt    = 1'b1;
            line_error_nxt = line_in_range;
          end
        end
        if (line_close) begin
          line_error_nxt = col_in_range & line_in_range;
          col_nxt        = '0;
          dropped_nxt    = 1'b0;
          if (line_in_range) line_nxt = line_cnt + YW'(1);
          else               over_nxt = 1'b1;
        end
        if (vs_fall) begin
          frame_end_nxt   = 1'b1;
          frame_count_nxt = frame_count + CW'(1);
          frame_error_nxt = (line_nxt != YW'(HEIGHT)) | over_nxt;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge mclk or negedge nreset) begin
    if (!nreset) begin
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      col_cnt     <= '0;
      line_cnt    <= '0;
      line_over   <= 1'b0;
      first_pix   <= 1'b0;
      dropped     <= 1'b0;
      pix_valid   <= 1'b0;
      pix_data    <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      line_error  <= 1'b0;
      frame_error <= 1'b0;
      frame_count <= '0;
      busy        <= 1'b0;
    end else begin
      hsync_q     <= hsync;
      vsync_q     <= vsync;
      col_cnt     <= col_nxt;
      line_cnt    <= line_nxt;
      line_over   <= over_nxt;
      first_pix   <= first_nxt;
      dropped     <= dropped_nxt;
      pix_valid   <= pix_valid_nxt;
      pix_data    <= pix_data_nxt;
      pix_x       <= pix_x_nxt;
      pix_y       <= pix_y_nxt;
      frame_start <= frame_start_nxt;
      frame_end   <= frame_end_nxt;
      line_error  <= line_error_nxt;
      frame_error <= frame_error_nxt;
      frame_count <= frame_count_nxt;
      busy        <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_hm01b0_capture.sv
// Bench for hm01b0_capture: a simulated camera drives frames described by a table (plus random
// frames); captured pixels and strobes are checked against a frame-level model of the image.
module tb_hm01b0_capture;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned HEIGHT = 4;
  localparam int unsigned XW     = 4;
  localparam int unsigned YW     = 3;

  logic          mclk = 1'b0;
  logic          nreset;
  logic          enable;
  logic [7:0]    pixdata;
  logic          hsync;
  logic          vsync;
  logic          pix_valid;
  logic [7:0]    pix_data;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          frame_start;
  logic          frame_end;
  logic          line_error;
  logic          frame_error;
  logic [15:0]   frame_count;
  logic          busy;

  hm01b0_capture #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .XW(XW), .YW(YW)) dut (
    .mclk(mclk), .nreset(nreset), .enable(enable), .pixdata(pixdata),
    .hsync(hsync), .vsync(vsync), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start), .frame_end(frame_end),
    .line_error(line_error), .frame_error(frame_error), .frame_count(frame_count),
    .busy(busy)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    int x;
    int y;
    int d;
    bit st;
  } pix_t;

  // One frame: line lengths in hsync cycles, enable at vsync rise / after line 0,
  // vsync cut under the last line, reset at a line index, expected counts (-1 = use model).
  typedef struct {
    int nl;
    int lens [6];
    bit en;
    bit en_mid;
    bit cut;
    int rst_line;
    int e_pix;
    int e_lerr;
    int e_ferr;
    int e_fend;
  } row_t;

  pix_t got_q[$];
  pix_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   got_lerr, got_ferr, got_fend, got_busy;
  int   exp_fcount = 0;
  bit   vs_prev = 1'b0;
  bit   hs_prev = 1'b0;
  row_t tbl [11];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic row_t mk(input int nl, input int l0, input int l1, input int l2,
                              input int l3, input int l4, input bit en, input bit en_mid,
                              input bit cut, input int rst, input int ep, input int el,
                              input int ef, input int efe);
    row_t r;
    r.nl = nl;
    r.lens[0] = l0; r.lens[1] = l1; r.lens[2] = l2;
    r.lens[3] = l3; r.lens[4] = l4; r.lens[5] = 0;
    r.en = en; r.en_mid = en_mid; r.cut = cut; r.rst_line = rst;
    r.e_pix = ep; r.e_lerr = el; r.e_ferr = ef; r.e_fend = efe;
    return r;
  endfunction

  // Monitor: outputs sampled 1ns after posedge; inputs are still the values just sampled.
  always @(posedge mclk) begin
    #1;
    if (nreset) begin
      if (pix_valid) begin
        got_q.push_back('{int'(pix_x), int'(pix_y), int'(pix_data), frame_start});
        chk("pix_data_vs_bus", int'(pix_data), int'(pixdata));
        chk("valid_while_busy", int'(busy), 1);
      end
      if (frame_start) chk("start_with_valid", int'(pix_valid), 1);
      if (frame_end) begin
        got_fend++;
        chk("frame_end_after_vfall", int'(vs_prev && !vsync), 1);
      end
      if (frame_error) begin
        got_ferr++;
        chk("ferr_with_fend", int'(frame_end), 1);
      end
      if (line_error) begin
        got_lerr++;
        chk("lerr_timing", int'((hs_prev && !hsync) || hsync), 1);
      end
      if (busy) got_busy++;
      vs_prev = vsync;
      hs_prev = hsync;
    end else begin
      vs_prev = 1'b0;
      hs_prev = 1'b0;
    end
  end

  task automatic run_row(input row_t r, input bit is_tbl);
    int  y;
    bit  cap;
    bit  first;
    int  mlerr;
    int  mferr;
    int  mfend;
    int  d;
    int  n;
    got_q.delete();
    exp_q.delete();
    got_lerr = 0; got_ferr = 0; got_fend = 0; got_busy = 0;
    y = 0; first = 1'b1; mlerr = 0; mferr = 0; mfend = 0;

    @(negedge mclk);
    enable = r.en; hsync = 1'b0; vsync = 1'b0; pixdata = 8'h00;
    repeat (3) @(negedge mclk);
    cap = r.en;
    vsync = 1'b1;
    repeat (WIDTH + 2) @(negedge mclk);

    for (int l = 0; l < r.nl; l++) begin
      if (l == r.rst_line) begin
        nreset = 1'b0;
        #1;
        chk("rst_mid_pix_valid", int'(pix_valid), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_frame_count", int'(frame_count), 0);
        cap = 1'b0;
        exp_fcount = 0;
        repeat (2) @(negedge mclk);
        nreset = 1'b1;
      end
      if (l == 1) enable = r.en_mid;
      hsync = 1'b0; pixdata = 8'h00;
      @(negedge mclk);
      for (int x = 0; x < r.lens[l]; x++) begin
        d = int'($urandom_range(0, 255));
        hsync = 1'b1; pixdata = 8'(d);
        if (cap && y < int'(HEIGHT) && x < int'(WIDTH)) begin
          exp_q.push_back('{x, y, d, first});
          first = 1'b0;
        end
        @(negedge mclk);
      end
      if (cap && y < int'(HEIGHT) && r.lens[l] != int'(WIDTH)) mlerr++;
      y++;
      if (r.cut && l == r.nl - 1) begin
        vsync = 1'b0; hsync = 1'b1; pixdata = 8'($urandom_range(0, 255));
        @(negedge mclk);
        hsync = 1'b0; pixdata = 8'h00;
        @(negedge mclk);
      end else begin
        hsync = 1'b0; pixdata = 8'h00;
        repeat (2) @(negedge mclk);
      end
    end
    if (!r.cut) begin
      repeat (3 * (WIDTH + 2)) @(negedge mclk);
      vsync = 1'b0;
      @(negedge mclk);
    end
    repeat (6) @(negedge mclk);

    if (cap) begin
      mfend = 1;
      mferr = (y != int'(HEIGHT)) ? 1 : 0;
    end

    chk("pix_count", got_q.size(), is_tbl ? r.e_pix : exp_q.size());
    chk("line_errors", got_lerr, is_tbl ? r.e_lerr : mlerr);
    chk("frame_errors", got_ferr, is_tbl ? r.e_ferr : mferr);
    chk("frame_ends", got_fend, is_tbl ? r.e_fend : mfend);
    exp_fcount += mfend;
    chk("frame_count", int'(frame_count), exp_fcount);
    chk("busy_seen", (got_busy > 0) ? 1 : 0, r.en ? 1 : 0);
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk("pix_x", got_q[i].x, exp_q[i].x);
      chk("pix_y", got_q[i].y, exp_q[i].y);
      chk("pix_value", got_q[i].d, exp_q[i].d);
      chk("frame_start_flag", int'(got_q[i].st), int'(exp_q[i].st));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    row_t r;
    nreset = 1'b0; enable = 1'b0; hsync = 1'b0; vsync = 1'b0; pixdata = 8'h00;

    //             nl  l0 l1  l2 l3 l4 en mid cut rst  pix lerr ferr fend
    tbl[0]  = mk(4,  8, 8,  8, 8, 0, 1, 1,  0,  -1,  32, 0,   0,   1);
    tbl[1]  = mk(4,  8, 6,  8, 8, 0, 1, 1,  0,  -1,  30, 1,   0,   1);
    tbl[2]  = mk(4,  8, 8, 10, 8, 0, 1, 1,  0,  -1,  32, 1,   0,   1);
    tbl[3]  = mk(3,  8, 8,  8, 0, 0, 1, 1,  0,  -1,  24, 0,   1,   1);
    tbl[4]  = mk(4,  8, 8,  8, 5, 0, 1, 1,  1,  -1,  29, 1,   0,   1);
    tbl[5]  = mk(5,  8, 8,  8, 8, 8, 1, 1,  0,  -1,  32, 0,   1,   1);
    tbl[6]  = mk(4,  8, 8,  8, 8, 0, 1, 1,  0,   2,  16, 0,   0,   0);
    tbl[7]  = mk(4,  8, 8,  8, 8, 0, 1, 1,  0,  -1,  32, 0,   0,   1);
    tbl[8]  = mk(4,  8, 8,  8, 8, 0, 1, 0,  0,  -1,  32, 0,   0,   1);
    tbl[9]  = mk(4,  8, 8,  8, 8, 0, 0, 0,  0,  -1,   0, 0,   0,   0);
    tbl[10] = mk(4,  8, 8,  8, 8, 0, 1, 1,  0,  -1,  32, 0,   0,   1);

    #2;
    chk("reset_pix_valid", int'(pix_valid), 0);
    chk("reset_pix_data", int'(pix_data), 0);
    chk("reset_pix_x", int'(pix_x), 0);
    chk("reset_pix_y", int'(pix_y), 0);
    chk("reset_frame_start", int'(frame_start), 0);
    chk("reset_frame_end", int'(frame_end), 0);
    chk("reset_line_error", int'(line_error), 0);
    chk("reset_frame_error", int'(frame_error), 0);
    chk("reset_frame_count", int'(frame_count), 0);
    chk("reset_busy", int'(busy), 0);
    repeat (3) @(negedge mclk);
    nreset = 1'b1;
    repeat (2) @(negedge mclk);

    for (int i = 0; i < 11; i++) run_row(tbl[i], 1'b1);

    for (int k = 0; k < 8; k++) begin
      r = mk(int'($urandom_range(3, 5)), 0, 0, 0, 0, 0, 1, 1,
             1'($urandom_range(0, 1)), -1, -1, -1, -1, -1);
      for (int l = 0; l < 6; l++) begin
        case ($urandom_range(0, 3))
          2:       r.lens[l] = int'(WIDTH) - int'($urandom_range(1, 3));
          3:       r.lens[l] = int'(WIDTH) + int'($urandom_range(1, 2));
          default: r.lens[l] = int'(WIDTH);
        endcase
      end
      run_row(r, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
